// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner_if
// Desc     : Pin-side and event-side signals of the matrix keypad scanner.
//            master = scanner (drives columns, reports key events),
//            slave  = keypad pins / consumer (drives rows, sees events).
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4
);
    localparam int KW = $clog2(ROWS * COLS);

    logic [ROWS-1:0] row;        // raw row sense lines, asynchronous
    logic [COLS-1:0] col;        // column strobe
    logic [KW-1:0]   key_code;   // code of the accepted key
    logic            key_valid;  // one-cycle pulse per accepted press
    logic            key_held;   // accepted key not yet released
    logic            multi_key;  // last completed scan saw >= 2 keys

    modport master (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held,
        output multi_key
    );

    modport slave (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  multi_key
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Desc     : Matrix keypad scanner. Rotates a one-hot column strobe with a
//            programmable dwell, samples synchronised rows at the end of each
//            dwell, encodes the lowest pressed key of every full scan and
//            reports one debounced event per press.
// Options  : KEYSCAN_DEBOUNCE_EN - when defined, a press or release needs
//            DEBOUNCE_SCANS consecutive agreeing scans; when undefined the
//            first clean scan is accepted and the first empty scan releases.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int STEP_CYCLES    = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter bit ACTIVE_LOW     = 1'b1,
    parameter int KW             = $clog2(ROWS * COLS)
) (
    input  logic             clk,
    input  logic             rst,
    keypad_scanner_if.master kp
);

    // ------------------------------------------------------------------
    // Derived sizes and constants
    // ------------------------------------------------------------------
    localparam int SW = $clog2(STEP_CYCLES);
    localparam int CW = $clog2(COLS);

    localparam logic [SW-1:0]   c_STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0]   c_COL_LAST  = CW'(COLS - 1);
    localparam logic [COLS-1:0] c_COL_FIRST = COLS'(1);

    // State encoding is shared by both builds so the PRESSED/IDLE codes
    // stay identical whether or not debounce is compiled in.
    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_PRESSED  = 2'd2;
`ifdef KEYSCAN_DEBOUNCE_EN
    localparam logic [1:0] c_DEBOUNCE = 2'd1;
    localparam logic [1:0] c_RELEASE  = 2'd3;
`endif

    // Out-of-range parameters make the scan timing meaningless (the
    // synchroniser needs at least 3 cycles of dwell), so stop elaboration.
    if (ROWS < 1 || COLS < 2 || STEP_CYCLES < 3 || DEBOUNCE_SCANS < 1 ||
        KW != $clog2(ROWS * COLS)) begin : g_param_check
        $error("keypad_scanner: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [ROWS-1:0] r_row_meta;
    logic [ROWS-1:0] r_row_sync;
    logic [ROWS-1:0] w_row_norm;

    logic [SW-1:0]   r_step;
    logic [CW-1:0]   r_col_idx;
    logic [COLS-1:0] r_col_oh;
    logic            w_sample;
    logic            w_scan_end;

    logic            w_col_found;
    logic            w_col_multi;
    logic [KW-1:0]   w_col_code;

    logic            r_acc_found;
    logic            r_acc_multi;
    logic [KW-1:0]   r_acc_code;
    logic            w_acc_live;
    logic            w_scan_found;
    logic            w_scan_multi;
    logic [KW-1:0]   w_scan_code;
    logic            w_clean;

    logic [1:0]      r_state;
    logic [KW-1:0]   r_key_code;
    logic            r_key_valid;
    logic            r_key_held;
    logic            r_multi_key;

    // ------------------------------------------------------------------
    // Row synchroniser and polarity normalisation
    // ------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous row pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_meta <= '0;
            r_row_sync <= '0;
        end else begin
            r_row_meta <= kp.row;
            r_row_sync <= r_row_meta;
        end
    end

    // A pressed key reads as 1 from here on regardless of pin polarity.
    assign w_row_norm = ACTIVE_LOW ? ~r_row_sync : r_row_sync;

    // ------------------------------------------------------------------
    // Dwell timer and column rotation
    // ------------------------------------------------------------------
    assign w_sample   = (r_step == c_STEP_LAST);
    assign w_scan_end = w_sample && (r_col_idx == c_COL_LAST);

    // Step counter wraps every STEP_CYCLES cycles; the last count is the sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step <= '0;
        end else if (w_sample) begin
            r_step <= '0;
        end else begin
            r_step <= r_step + SW'(1);
        end
    end

    // Column index and its one-hot strobe advance together after each sample,
    // so the pin strobe comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_idx <= '0;
            r_col_oh  <= c_COL_FIRST;
        end else if (w_sample) begin
            r_col_oh <= {r_col_oh[COLS-2:0], r_col_oh[COLS-1]};
            if (r_col_idx == c_COL_LAST) begin
                r_col_idx <= '0;
            end else begin
                r_col_idx <= r_col_idx + CW'(1);
            end
        end
    end

    assign kp.col = ACTIVE_LOW ? ~r_col_oh : r_col_oh;

    // ------------------------------------------------------------------
    // Per-column key encoding
    // ------------------------------------------------------------------
    // Walk rows from the top down so the lowest pressed row wins the code;
    // a second pressed row in the same column flags a multi-key.
    always_comb begin
        w_col_found = 1'b0;
        w_col_multi = 1'b0;
        w_col_code  = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (w_row_norm[r]) begin
                if (w_col_found) begin
                    w_col_multi = 1'b1;
                end
                w_col_found = 1'b1;
                w_col_code  = KW'(r * COLS) + KW'(r_col_idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // Scan accumulator
    // ------------------------------------------------------------------
    // Column 0 starts a new scan, so the stored accumulator is ignored there.
    assign w_acc_live   = (r_col_idx != '0);
    assign w_scan_found = (w_acc_live && r_acc_found) || w_col_found;
    assign w_scan_multi = w_col_multi ||
                          (w_acc_live && (r_acc_multi || (r_acc_found && w_col_found)));
    assign w_clean      = w_scan_found && !w_scan_multi;

    // Codes interleave across columns (row*COLS+col), so an earlier column can
    // hold a larger code; keep the numerically lowest one seen this scan.
    always_comb begin
        w_scan_code = w_col_code;
        if (w_acc_live && r_acc_found && (!w_col_found || (r_acc_code < w_col_code))) begin
            w_scan_code = r_acc_code;
        end
    end

    // Fold each column sample into the running scan summary.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_found <= 1'b0;
            r_acc_multi <= 1'b0;
            r_acc_code  <= '0;
        end else if (w_sample) begin
            r_acc_found <= w_scan_found;
            r_acc_multi <= w_scan_multi;
            r_acc_code  <= w_scan_code;
        end
    end

    // Multi-key flag reflects the most recently completed scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_multi_key <= 1'b0;
        end else if (w_scan_end) begin
            r_multi_key <= w_scan_multi;
        end
    end

    // ------------------------------------------------------------------
    // Key event state machine, evaluated once per completed scan
    // ------------------------------------------------------------------
`ifdef KEYSCAN_DEBOUNCE_EN
    localparam int                CNTW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNTW-1:0]   c_CNT_ONE    = CNTW'(1);
    localparam logic [CNTW-1:0]   c_CNT_TARGET = CNTW'(DEBOUNCE_SCANS);

    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_inc;
    logic [KW-1:0]   r_cand;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    // Press needs DEBOUNCE_SCANS identical clean scans; release needs the same
    // number of consecutive empty scans. Only one event per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_cand      <= '0;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_scan_end) begin
                case (r_state)
                    c_IDLE: begin
                        if (w_clean) begin
                            r_cand <= w_scan_code;
                            r_cnt  <= c_CNT_ONE;
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state     <= c_PRESSED;
                                r_key_code  <= w_scan_code;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                            end else begin
                                r_state <= c_DEBOUNCE;
                            end
                        end
                    end
                    c_DEBOUNCE: begin
                        if (w_clean && (w_scan_code == r_cand)) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_CNT_TARGET) begin
                                r_state     <= c_PRESSED;
                                r_key_code  <= r_cand;
                                r_key_valid <= 1'b1;
                                r_key_held  <= 1'b1;
                            end
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end
                    c_PRESSED: begin
                        // Any scan with a key present (even another key or a
                        // multi-key) keeps the current press alive.
                        if (!w_scan_found) begin
                            r_cnt <= c_CNT_ONE;
                            if (DEBOUNCE_SCANS == 1) begin
                                r_state    <= c_IDLE;
                                r_key_held <= 1'b0;
                            end else begin
                                r_state <= c_RELEASE;
                            end
                        end
                    end
                    c_RELEASE: begin
                        if (!w_scan_found) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_CNT_TARGET) begin
                                r_state    <= c_IDLE;
                                r_key_held <= 1'b0;
                            end
                        end else begin
                            r_state <= c_PRESSED;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end
`else
    // First clean scan is accepted at once; first empty scan releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_scan_end) begin
                case (r_state)
                    c_IDLE: begin
                        if (w_clean) begin
                            r_state     <= c_PRESSED;
                            r_key_code  <= w_scan_code;
                            r_key_valid <= 1'b1;
                            r_key_held  <= 1'b1;
                        end
                    end
                    c_PRESSED: begin
                        if (!w_scan_found) begin
                            r_state    <= c_IDLE;
                            r_key_held <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;
    assign kp.multi_key = r_multi_key;

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner: drives a rotating one-hot column strobe with a programmable dwell, samples synchronised row inputs, and reports one debounced key event per press. It sits between the keypad pins and the input-decoding logic, replacing the free-running column-rotation block. It adds dwell timing, polarity selection, row sensing, key encoding, multi-key detection and press/release debounce.

## Interface

- ROWS, 4, number of row inputs (≥1)
- COLS, 4, number of column strobes (≥2)
- STEP_CYCLES, 1000, clk cycles each column stays active (≥3)
- DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release (≥1)
- ACTIVE_LOW, 1, 1: active column driven 0 and pressed row reads 0; 0: both active-high
- KW, $clog2(ROWS*COLS), key_code width (derived; do not override)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row  in  ROWS  raw row sense lines, asynchronous to clk
- col  out  COLS  column strobe, one-hot (inverted when ACTIVE_LOW)
- key_code  out  KW  code of accepted key: row_idx*COLS + col_idx
- key_valid  out  1  one-cycle pulse per accepted press
- key_held  out  1  high from acceptance until release is accepted
- multi_key  out  1  last completed scan saw ≥2 pressed keys

## Operation

- Rows pass through a 2-flop synchroniser and are normalised to active-high (inverted when ACTIVE_LOW=1).
- Step counter runs 0..STEP_CYCLES-1. On the final count, the normalised rows are sampled for the current column. The column index then advances mod COLS on the next cycle.
- Per-scan accumulator records:
  - found: ≥1 pressed key
  - code: lowest pressed code
  - multi: ≥2 pressed keys
- The accumulator clears at scan start. A scan ends at the sample of column COLS-1. multi_key updates at each scan end.
- A "clean" scan means found && !multi. The FSM is evaluated only at scan end.
  - IDLE: clean scan → load cand=code, cnt=1. Go to PRESSED if DEBOUNCE_SCANS==1, otherwise DEBOUNCE. Any other scan → stay in IDLE.
  - DEBOUNCE: clean scan with code==cand → cnt+1. When cnt reaches DEBOUNCE_SCANS → PRESSED. Any other scan → IDLE.
  - Entry into PRESSED: key_code←cand, key_valid pulses, key_held←1.
  - PRESSED: !found → RELEASE with cnt=1. When DEBOUNCE_SCANS==1, go directly to IDLE instead. Any found scan (different key or multi included) → stay in PRESSED; no new event until release.
  - RELEASE: !found → cnt+1. When cnt reaches DEBOUNCE_SCANS → IDLE and key_held←0. A found scan → PRESSED with no new key_valid.
- key_code holds its value until the next accepted press.

## Timing

- Reset values:
  - col = column 0 active (4'b1110 for COLS=4, ACTIVE_LOW=1)
  - step and column counters 0, FSM IDLE
  - key_code 0, key_valid 0, key_held 0, multi_key 0
  - synchroniser and accumulator cleared
- Reset asserted mid-scan or mid-debounce aborts all activity. No key_valid is emitted for the aborted press.
- Column dwell is exactly STEP_CYCLES cycles; scan period is COLS*STEP_CYCLES.
- key_valid, key_held rise, key_held fall and multi_key updates all take effect on the cycle after the scan-end sample.
- Press latency from a row edge: 2 synchroniser cycles + wait for that column's sample + completion of DEBOUNCE_SCANS clean scans.
- A row change within 2 cycles of a sample may land in either the current or the next scan.

## Configuration

- KEYSCAN_DEBOUNCE_EN defined:
  - Press and release debounce behave as described in Operation.
- KEYSCAN_DEBOUNCE_EN undefined:
  - DEBOUNCE_SCANS is ignored and treated as 1. DEBOUNCE and RELEASE states and the cnt register are not built.
  - IDLE→PRESSED on the first clean scan; PRESSED→IDLE on the first empty scan.

## Test plan

All scenarios use ROWS=4, COLS=4, STEP_CYCLES=4, DEBOUNCE_SCANS=3, ACTIVE_LOW=1, with KEYSCAN_DEBOUNCE_EN defined.

- Reset: rst=1 for 2 cycles, rows all 1 → col=1110 and all outputs 0. After reset, col holds 1110, 1101, 1011, 0111 for 4 cycles each, then wraps to 1110.
- Single press: row[2]=0 whenever col[1]=0, held 200 cycles → exactly one key_valid with key_code=9, then key_held=1. No further pulses.
- Bounce: same key present for 1 scan only → no key_valid; FSM returns to IDLE.
- Multi-key: key 0 and key 15 held together → multi_key=1, no key_valid, key_held stays 0.
- Release: after scenario 2, release the key, with a 1-scan glitch on the second empty scan → key_held stays 1. key_held falls only after 3 consecutive empty scans, and no second key_valid occurs.
- Mid-operation reset: rst pulse during DEBOUNCE (after 2 clean scans) → no key_valid, outputs at reset values, col restarts at 1110.
